// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter unit and its return-address stack.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

  // Action the PC takes on one enabled edge, in decreasing priority order RET > CALL > JUMP > STEP.
  typedef enum logic [2:0] {
    PC_HOLD,
    PC_STEP,
    PC_JUMP,
    PC_CALL,
    PC_RET
  } pc_action_e;

  localparam int          PC_WIDTH_DEF     = 32;
  localparam int          PC_STEP_DEF      = 4;
  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
  localparam int          RAS_DEPTH_DEF    = 4;

  // Index width for a RAS of the given depth; never narrower than one bit.
  function automatic int ras_ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_unit_ras_if.sv
// Control/observation bundle between decode/execute and the PC unit.
// Latency: n/a (wires only).
// Backpressure: none; wEn=0 stalls the PC unit.
// master: drives wEn/redirect/call/ret/target, observes PCout and RAS flags.
// slave : the PC unit itself.
interface pc_unit_ras_if #(
  parameter int WIDTH = 32
);
  logic             wEn;
  logic             redirect;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] PCout;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output wEn, redirect, call, ret, target,
    input  PCout, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  wEn, redirect, call, ret, target,
    output PCout, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full.
// Latency: push/pop take effect on the next edge; top_dat_o is the registered top entry.
// Backpressure: none; overflow/underflow reported as one-cycle flag pulses.
// Ports: clock/reset, push_i + push_dat_i, pop_i, top_dat_o, empty_o, full_o, ovf_o, unf_o.
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = RAS_DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic [WIDTH-1:0] top_dat_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam int             PW       = ras_ptr_width(DEPTH);
  localparam int             CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;
  logic [PW-1:0]    wr_ptr;

  // DEPTH is a power of two, so pointer arithmetic wraps around the buffer for free.
  assign wr_ptr    = top_q + PW'(1);
  assign top_dat_o = mem_q[top_q];
  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == FULL_CNT);
  assign ovf_o     = ovf_q;
  assign unf_o     = unf_q;

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    wr_en = 1'b0;
    if (push_i) begin
      // When full, top+1 is the oldest entry: it is overwritten and count saturates.
      wr_en = 1'b1;
      top_d = wr_ptr;
      ovf_d = full_o;
      if (!full_o) cnt_d = cnt_q + CW'(1);
    end else if (pop_i) begin
      if (empty_o) begin
        unf_d = 1'b1;
      end else begin
        top_d = top_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      top_q <= PTR_LAST;  // first push then lands in entry 0
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry contents need no reset; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr] <= push_dat_i;
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch program counter with stall, step, jump, call and return via an internal RAS.
// Latency: 1 cycle from sampled controls to PCout.
// Backpressure: wEn=0 holds PC and RAS and ignores all requests.
// Ports: clock, reset (sync, active-high), bus (slave: wEn/redirect/call/ret/target in;
//        PCout, ras_empty/ras_full/ras_ovf/ras_unf out).
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC_DEF),
  parameter int               STEP      = PC_STEP_DEF,
  parameter int               RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic          clock,
  input  logic          reset,
  pc_unit_ras_if.slave  bus
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  pc_action_e       action;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  // Also the value pushed on a call; wraps modulo 2^WIDTH.
  assign pc_inc = pc_q + STEP_W;

  // One action per enabled edge; lower-priority requests are dropped.
  always_comb begin
    action = PC_HOLD;
    if (bus.wEn) begin
      if (bus.ret)           action = PC_RET;
      else if (bus.call)     action = PC_CALL;
      else if (bus.redirect) action = PC_JUMP;
      else                   action = PC_STEP;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (action)
      PC_HOLD: pc_d = pc_q;
      PC_STEP: pc_d = pc_inc;
      PC_JUMP: pc_d = bus.target;
      PC_CALL: pc_d = bus.target;
      // A return with nothing on the stack degrades to a sequential step.
      PC_RET:  pc_d = ras_empty ? pc_inc : ras_top;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) pc_q <= RESET_VEC;
    else       pc_q <= pc_d;
  end

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock      (clock),
    .reset      (reset),
    .push_i     (action == PC_CALL),
    .pop_i      (action == PC_RET),
    .push_dat_i (pc_inc),
    .top_dat_o  (ras_top),
    .empty_o    (ras_empty),
    .full_o     (ras_full),
    .ovf_o      (ras_ovf),
    .unf_o      (ras_unf)
  );

  assign bus.PCout     = pc_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_ovf   = ras_ovf;
  assign bus.ras_unf   = ras_unf;

endmodule
